// File: rtl/program_loader_seq_pkg.sv
// Shared definitions for the program loader: FSM state encoding and memory access constants.
package program_loader_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] ACC_WORD   = 2'b00;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/program_loader_seq_lat_pipe.sv
// loader_lat_pipe: DEPTH-deep shift of {valid, pc} that lines each read issue up with its returning data.
module loader_lat_pipe #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_pc,
    output logic              tail_valid,
    output logic [ADDR_W-1:0] tail_pc,
    output logic              busy
);

    logic [DEPTH-1:0]  valid_r;
    logic [ADDR_W-1:0] pc_r [DEPTH];

    // Shift register; pc is zeroed on empty slots so insn_pc reads 0 when nothing is returning.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i] <= '0;
            end
        end else begin
            valid_r[0] <= in_valid;
            pc_r[0]    <= in_valid ? in_pc : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                pc_r[i]    <= pc_r[i-1];
            end
        end
    end

    // Busy covers every stage except the tail, so the caller can finish on the tail's last cycle.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            busy = busy | valid_r[i];
        end
    end

    assign tail_valid = valid_r[DEPTH-1];
    assign tail_pc    = pc_r[DEPTH-1];

endmodule

// File: rtl/program_loader_seq.sv
// program_loader_seq: streams a program into mainMem, then fetches it back in order for decode.
// Optional feature macro LOADER_CHECKSUM_EN adds the checksum and fetch_mismatch ports.
module program_loader_seq
    import program_loader_seq_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = 32'h8002_0000,
    parameter int                MAX_WORDS  = 1024,
    parameter int                MEM_LAT    = 2,
    localparam int               CNT_W      = $clog2(MAX_WORDS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    output logic              mem_enable,
    output logic [1:0]        mem_acc_size,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] insn,
    output logic [ADDR_W-1:0] insn_pc,
    output logic              insn_valid,
    output logic [CNT_W-1:0]  word_count,
    output logic              done,
`ifdef LOADER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
    output logic              fetch_mismatch,
`endif
    output logic              overflow
);

    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(WORD_BYTES);

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  count_r, count_s, issue_r, issue_s;
    logic [ADDR_W-1:0] pc_r, pc_s, mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              mem_wren_r, mem_wren_s, mem_enable_r, mem_enable_s;
    logic              in_ready_r, in_ready_s, done_r, done_s, overflow_r, overflow_s;
    logic              accept_s, clear_s, finish_s, ovf_set_s, read_inflight_s;
    logic              tail_valid_s, pipe_busy_s;
    logic [ADDR_W-1:0] tail_pc_s;

    assign accept_s        = (state_r == ST_LOAD) && in_valid && in_ready_r;
    assign read_inflight_s = mem_enable_r && !mem_wren_r;

    // The registered read issue feeds the pipe, so its tail lines up with mem_rdata MEM_LAT cycles later.
    loader_lat_pipe #(
        .DEPTH  (MEM_LAT),
        .ADDR_W (ADDR_W)
    ) u_lat_pipe (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (read_inflight_s),
        .in_pc      (mem_addr_r),
        .tail_valid (tail_valid_s),
        .tail_pc    (tail_pc_s),
        .busy       (pipe_busy_s)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        issue_s      = issue_r;
        pc_s         = pc_r;
        mem_addr_s   = '0;
        mem_wdata_s  = '0;
        mem_wren_s   = 1'b0;
        mem_enable_s = 1'b0;
        clear_s      = 1'b0;
        finish_s     = 1'b0;
        ovf_set_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_LOAD;
                    clear_s = 1'b1;
                    count_s = '0;
                    issue_s = '0;
                    pc_s    = START_ADDR;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    mem_addr_s   = START_ADDR + ADDR_W'(count_r) * STEP;
                    mem_wdata_s  = in_data;
                    mem_wren_s   = 1'b1;
                    mem_enable_s = 1'b1;
                    count_s      = count_r + CNT_W'(1);
                    if (in_last) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else if (in_valid && (count_r == MAX_CNT)) begin
                    ovf_set_s = 1'b1;
                    state_s   = ST_RUN;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (issue_r >= count_r) begin
                    state_s = ST_DRAIN;
                end else if (!stall) begin
                    mem_addr_s   = pc_r;
                    mem_enable_s = 1'b1;
                    pc_s         = pc_r + STEP;
                    issue_s      = issue_r + CNT_W'(1);
                    if ((issue_r + CNT_W'(1)) == count_r) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!pipe_busy_s && !read_inflight_s) begin
                    finish_s = 1'b1;
                    state_s  = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        in_ready_s = (state_s == ST_LOAD) && (count_s < MAX_CNT);
        done_s     = clear_s ? 1'b0 : (done_r | finish_s);
        overflow_s = clear_s ? 1'b0 : (overflow_r | ovf_set_s);
    end

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            count_r      <= '0;
            issue_r      <= '0;
            pc_r         <= '0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            mem_wren_r   <= 1'b0;
            mem_enable_r <= 1'b0;
            in_ready_r   <= 1'b0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            issue_r      <= issue_s;
            pc_r         <= pc_s;
            mem_addr_r   <= mem_addr_s;
            mem_wdata_r  <= mem_wdata_s;
            mem_wren_r   <= mem_wren_s;
            mem_enable_r <= mem_enable_s;
            in_ready_r   <= in_ready_s;
            done_r       <= done_s;
            overflow_r   <= overflow_s;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_r, fold_r;
    logic              mismatch_r;

    // Load-side XOR versus delivered-insn XOR; insn is zero when not valid, so it folds in safely.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            checksum_r <= '0;
            fold_r     <= '0;
            mismatch_r <= 1'b0;
        end else if (clear_s) begin
            checksum_r <= '0;
            fold_r     <= '0;
            mismatch_r <= 1'b0;
        end else begin
            if (accept_s) begin
                checksum_r <= checksum_r ^ in_data;
            end
            if (tail_valid_s) begin
                fold_r <= fold_r ^ mem_rdata;
            end
            if (finish_s && ((fold_r ^ insn) != checksum_r)) begin
                mismatch_r <= 1'b1;
            end
        end
    end

    assign checksum       = checksum_r;
    assign fetch_mismatch = mismatch_r;
`endif

    assign in_ready     = in_ready_r;
    assign mem_addr     = mem_addr_r;
    assign mem_wdata    = mem_wdata_r;
    assign mem_wren     = mem_wren_r;
    assign mem_enable   = mem_enable_r;
    assign mem_acc_size = ACC_WORD;
    assign insn_valid   = tail_valid_s;
    assign insn         = tail_valid_s ? mem_rdata : '0;
    assign insn_pc      = tail_pc_s;
    assign word_count   = count_r;
    assign done         = done_r;
    assign overflow     = overflow_r;

endmodule
